uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared constants for the UART transmit arbiter
package uart_tx_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SEND    = 2'd1;
  localparam logic [1:0] ST_WAIT_HI = 2'd2;
  localparam logic [1:0] ST_WAIT_LO = 2'd3;

  localparam logic [7:0] HDR_BASE = 8'hA0;

  function automatic logic [7:0] header_byte(input logic [1:0] id);
    return HDR_BASE | {6'b0, id};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick; the caller owns the pointer register
module rr_arbiter
  import uart_tx_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  logic [IW-1:0] cand;

  // Scan from ptr upward with wrap; the first set request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART transmitter among NUM_REQ word requesters
// UART_TX_HEADER_EN: prefix each word with header byte 8'hA0 | cur_id
module uart_tx_arbiter
  import uart_tx_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int WORD_BYTES = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*8*WORD_BYTES-1:0]   req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              tx_start,
  output logic [7:0]                        tx_data,
  input  logic                              tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]        cur_id
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = 8 * WORD_BYTES;
`ifdef UART_TX_HEADER_EN
  localparam int NBYTES = WORD_BYTES + 1;
`else
  localparam int NBYTES = WORD_BYTES;
`endif
  localparam int FW = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [IW-1:0]      rr_ptr;
  logic [FW-1:0]      frame;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               grant_any;
  logic [IW-1:0]      next_ptr;
  logic [WW-1:0]      win_word;
  logic [FW-1:0]      win_frame;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    win_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_word = req_data[i*WW +: WW];
    end
  end

  // The frame is kept LSB-first so each strobe just takes the low byte and shifts.
`ifdef UART_TX_HEADER_EN
  assign win_frame = {win_word, header_byte(2'(grant_idx))};
`else
  assign win_frame = win_word;
`endif

  assign next_ptr = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rr_ptr    <= '0;
      frame     <= '0;
      req_ready <= '0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      cur_id    <= '0;
    end else begin
      req_ready <= '0;
      tx_start  <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Grant, acknowledge and first strobe all leave on the same edge.
          if (grant_any) begin
            req_ready <= grant;
            cur_id    <= grant_idx;
            rr_ptr    <= next_ptr;
            cnt       <= '0;
            tx_start  <= 1'b1;
            tx_data   <= win_frame[7:0];
            frame     <= win_frame >> 8;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          state <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (tx_busy) state <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (!tx_busy) begin
            if (cnt < LAST) begin
              cnt      <= cnt + 1'b1;
              tx_start <= 1'b1;
              tx_data  <= frame[7:0];
              frame    <= frame >> 8;
              state    <= ST_SEND;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter (NUM_REQ=2, WORD_BYTES=2)
module tb_uart_tx_arbiter;

  localparam int N  = 2;
  localparam int WB = 2;
  localparam int WW = 8 * WB;
`ifdef UART_TX_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int NB     = WB + HDR;
  localparam int STARVE = 300;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*WW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy = 1'b0;
  logic [0:0]      cur_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ    (N),
    .WORD_BYTES (WB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .cur_id    (cur_id)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int         mptr = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  logic [7:0] last_byte = 8'h00;
  int         n_strobes = 0;
  int         n_grants = 0;
  bit         got_ready = 0;
  int         last_gid = -1;
  int         wait_cnt[N];
  bit         rand_req = 0;
  bit         rand_tx = 0;
  // transmitter model
  bit         arm = 0;
  int         dly = 0;
  int         plen = 1;
  int         bcnt = 0;
  int         cur_dly = 0;
  int         cur_len = 4;

  typedef struct {
    bit          rst;
    logic [1:0]  valid;
    logic [15:0] w0;
    logic [15:0] w1;
    int          dly;
    int          len;
    int          exp_id;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int i = (p + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // One clock: observe outputs at the falling edge, update models, then drive inputs.
  task automatic cycle();
    @(negedge clk);
    if (rst) return;
    if (req_ready != '0) begin
      int w = rr_pick(req_valid, mptr);
      chk("grant_onehot", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
      chk("grant_with_start", 32'(tx_start), 32'd1);
      if (w >= 0) begin
        chk("cur_id", 32'(cur_id), 32'(w));
`ifdef UART_TX_HEADER_EN
        exp_q.push_back(8'hA0 | 8'(w));
`endif
        for (int b = 0; b < WB; b++) exp_q.push_back(req_data[w*WW + 8*b +: 8]);
        mptr = (w + 1) % N;
        got_ready = 1;
        last_gid = w;
        n_grants++;
        req_valid[w] = 1'b0;
        wait_cnt[w] = 0;
        if (rand_req) req_data[w*WW +: WW] = WW'($urandom);
      end
    end
    if (tx_start) begin
      chk("no_strobe_while_busy", {31'b0, arm | tx_busy}, 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_strobe: got %0h expected none", tx_data);
      end else begin
        chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      cap_q.push_back(tx_data);
      last_byte = tx_data;
      n_strobes++;
    end else begin
      chk("tx_data_hold", 32'(tx_data), 32'(last_byte));
    end
    if (tx_start) begin
      arm  = 1;
      dly  = rand_tx ? $urandom_range(0, 3) : cur_dly;
      plen = rand_tx ? $urandom_range(1, 8) : cur_len;
    end else if (arm) begin
      if (dly == 0) begin
        arm = 0;
        tx_busy = 1'b1;
        bcnt = plen;
      end else begin
        dly--;
      end
    end else if (tx_busy) begin
      bcnt--;
      if (bcnt <= 0) tx_busy = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i]) begin
        wait_cnt[i]++;
        if (wait_cnt[i] > STARVE) begin
          n_cmp++;
          n_err++;
          $display("FAIL starvation: requester %0d waited %0d cycles, limit %0d", i, wait_cnt[i], STARVE);
          wait_cnt[i] = 0;
        end
      end
      if (rand_req && !req_valid[i] && $urandom_range(0, 3) == 0) begin
        req_data[i*WW +: WW] = WW'($urandom);
        req_valid[i] = 1'b1;
        wait_cnt[i] = 0;
      end
    end
  endtask

  // Entered at a falling edge; reset is raised mid-cycle to show it acts without a clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_cur_id", 32'(cur_id), 32'd0);
    req_valid = '0;
    exp_q.delete();
    cap_q.delete();
    mptr = 0;
    last_byte = 8'h00;
    arm = 0;
    tx_busy = 1'b0;
    bcnt = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int lim);
    bit done = 0;
    for (int t = 0; t < lim; t++) begin
      if (req_valid == '0 && exp_q.size() == 0 && !tx_busy && !arm) begin
        done = 1;
        break;
      end
      cycle();
    end
    chk("drain_idle", {31'b0, done}, 32'd1);
    repeat (3) cycle();
  endtask

  task automatic wait_grant(input int lim);
    for (int t = 0; t < lim && !got_ready; t++) cycle();
    chk("grant_seen", {31'b0, got_ready}, 32'd1);
  endtask

  initial begin
    int s0;
    tv[0] = '{1'b1, 2'b01, 16'hBEEF, 16'h0000, 0, 10, 0, 8'hEF, 8'hBE};
    tv[1] = '{1'b1, 2'b11, 16'h1111, 16'h2222, 1, 3,  0, 8'h11, 8'h11};
    tv[2] = '{1'b0, 2'b10, 16'h0000, 16'h2222, 3, 2,  1, 8'h22, 8'h22};
    tv[3] = '{1'b0, 2'b11, 16'h1111, 16'h2222, 0, 2,  0, 8'h11, 8'h11};
    tv[4] = '{1'b0, 2'b10, 16'h0000, 16'h2222, 0, 2,  1, 8'h22, 8'h22};
    tv[5] = '{1'b0, 2'b10, 16'h0000, 16'h1234, 1, 2,  1, 8'h34, 8'h12};
    tv[6] = '{1'b0, 2'b11, 16'h00FF, 16'hABCD, 2, 1,  0, 8'hFF, 8'h00};
    tv[7] = '{1'b0, 2'b10, 16'h0000, 16'hABCD, 0, 1,  1, 8'hCD, 8'hAB};
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;

    @(negedge clk);
    for (int e = 0; e < 8; e++) begin
      if (tv[e].rst) do_reset();
      cur_dly = tv[e].dly;
      cur_len = tv[e].len;
      req_data = {tv[e].w1, tv[e].w0};
      req_valid = tv[e].valid;
      cap_q.delete();
      got_ready = 0;
      wait_grant(300);
      chk("tbl_grant_id", 32'(last_gid), 32'(tv[e].exp_id));
      for (int t = 0; t < 600 && cap_q.size() < NB; t++) cycle();
      chk("tbl_strobes", 32'(cap_q.size()), 32'(NB));
      if (cap_q.size() >= NB) begin
`ifdef UART_TX_HEADER_EN
        chk("tbl_header", 32'(cap_q[0]), 32'(8'hA0 | 8'(tv[e].exp_id)));
`endif
        chk("tbl_byte0", 32'(cap_q[HDR]), 32'(tv[e].b0));
        chk("tbl_byte1", 32'(cap_q[HDR+1]), 32'(tv[e].b1));
      end
    end
    drain(500);

    // Reset between the two data bytes of 16'hCAFE abandons the rest of the word.
    do_reset();
    cur_dly = 0;
    cur_len = 4;
    req_data = {16'h0000, 16'hCAFE};
    req_valid = 2'b01;
    for (int t = 0; t < 300 && cap_q.size() < HDR + 1; t++) cycle();
    chk("abort_first_byte", (cap_q.size() > HDR) ? 32'(cap_q[HDR]) : 32'hFFFF_FFFF, 32'h0000_00FE);
    repeat (2) cycle();
    do_reset();
    s0 = n_strobes;
    repeat (30) cycle();
    chk("abort_no_more_strobes", 32'(n_strobes), 32'(s0));
    req_data = {16'h2222, 16'h1111};
    req_valid = 2'b11;
    got_ready = 0;
    wait_grant(50);
    chk("post_reset_first_id", 32'(last_gid), 32'd0);
    drain(500);

    // Randomized traffic against the model.
    s0 = n_grants;
    rand_req = 1;
    rand_tx = 1;
    repeat (4000) cycle();
    rand_req = 0;
    drain(3000);
    chk("random_grants_made", {31'b0, (n_grants - s0) > 50}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
